// File: rtl/sram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_pkg
//
// Shared CPU package for the single-port SRAM arbiter.
//   - Owner state encoding of the read-return register (IDLE / INST_RD / DATA_RD).
//   - Byte-enable constant that marks a read access (no byte lanes written).
//   - Small helpers used by the arbiter's grant and return-tracking logic.
// -----------------------------------------------------------------------------
package sram_port_arbiter_pkg;

  // Owner of the SRAM read data returning in the current cycle.
  localparam int unsigned OWNER_W = 2;

  localparam logic [OWNER_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [OWNER_W-1:0] ST_INST_RD = 2'd1;
  localparam logic [OWNER_W-1:0] ST_DATA_RD = 2'd2;

  // Byte write enables of all zero encode a read.
  localparam logic [3:0] WEN_READ = 4'b0000;

  // Data bus width of both requester ports and the SRAM.
  localparam int unsigned DW = 32;

  // A data access is a read exactly when no byte lane is written.
  function automatic logic is_read(input logic [3:0] wen);
    return (wen == WEN_READ);
  endfunction

  // Counter width able to hold 0..limit. A limit of 0 still needs one bit
  // so the counter never collapses to a zero-width vector.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage : sram_port_arbiter_pkg

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port synchronous SRAM between an instruction-fetch port
// (read only) and a load/store data port. Arbitration is combinational: the
// winning request is granted and drives the SRAM in the same cycle it is seen.
// Data normally wins a collision; after STARVE_LIMIT consecutive data grants
// against a pending fetch, the fetch wins once. Read data returns one cycle
// after the grant and is steered by a small owner-state register.
//
// Parameters
//   STARVE_LIMIT  max consecutive data grants while inst_req is pending
//   AW            address width
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_req/addr            fetch request (held until granted)
//   inst_gnt                 fetch accepted this cycle
//   inst_rvalid/rdata        fetch read return
//   data_req/wen/addr/wdata  load/store request (held until granted)
//   data_gnt                 load/store accepted this cycle
//   data_rvalid/rdata        load read return (never for stores)
//   sram_en/wen/addr/wdata   SRAM command, all zero when idle
//   sram_rdata               SRAM read data, one cycle after a read command
// -----------------------------------------------------------------------------
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_gnt,
  output logic          inst_rvalid,
  output logic [DW-1:0] inst_rdata,

  input  logic          data_req,
  input  logic [3:0]    data_wen,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_gnt,
  output logic          data_rvalid,
  output logic [DW-1:0] data_rdata,

  output logic          sram_en,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  localparam int unsigned CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  logic [OWNER_W-1:0] state_q, state_d;
  logic [CW-1:0]      starve_cnt_q, starve_cnt_d;

  logic inst_win;
  logic data_win;
  logic starved;

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  // Fetch wins when it is alone, or when data has already taken the maximum
  // number of consecutive grants against it. Reset masks every grant so no
  // request can touch the SRAM while rst is high.
  assign starved  = (starve_cnt_q == CNT_MAX);
  assign inst_win = inst_req && (!data_req || starved);
  assign data_win = data_req && !inst_win;

  assign inst_gnt = inst_win && !rst;
  assign data_gnt = data_win && !rst;

  // ---------------------------------------------------------------------------
  // SRAM command mux
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = WEN_READ;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end else if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: read owner and starvation counter
  // ---------------------------------------------------------------------------
  // Only reads produce a return, so a data write leaves the owner idle.
  always_comb begin
    state_d = ST_IDLE;
    if (inst_gnt) begin
      state_d = ST_INST_RD;
    end else if (data_gnt && is_read(data_wen)) begin
      state_d = ST_DATA_RD;
    end
  end

  // The counter measures how long the fetch has waited behind data. It
  // restarts whenever the fetch is served or stops asking; the saturation
  // guard is defensive since a saturated counter already forces a fetch win.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (inst_gnt || !inst_req) begin
      starve_cnt_d = '0;
    end else if (data_gnt && !starved) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  // A read granted in the cycle before reset rises is cancelled: the owner
  // register still holds the old value until the reset edge, so the return
  // is masked with rst directly.
  assign inst_rvalid = (state_q == ST_INST_RD) && !rst;
  assign data_rvalid = (state_q == ST_DATA_RD) && !rst;

  // Both ports see the raw SRAM data; consumers qualify it with rvalid.
  assign inst_rdata = sram_rdata;
  assign data_rdata = sram_rdata;

endmodule : sram_port_arbiter

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter (STARVE_LIMIT=4, AW=32). Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter #(
    .STARVE_LIMIT(4),
    .AW          (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_gnt   (inst_gnt),
    .inst_rvalid(inst_rvalid),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata (data_rdata),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd);
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wen   = dw;
    data_addr  = da;
    data_wdata = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".inst_gnt"},    {31'd0, inst_gnt},    32'd0);
    chk({tag, ".data_gnt"},    {31'd0, data_gnt},    32'd0);
    chk({tag, ".inst_rvalid"}, {31'd0, inst_rvalid}, 32'd0);
    chk({tag, ".data_rvalid"}, {31'd0, data_rvalid}, 32'd0);
    chk({tag, ".sram_en"},     {31'd0, sram_en},     32'd0);
    chk({tag, ".sram_wen"},    {28'd0, sram_wen},    32'd0);
    chk({tag, ".sram_addr"},   sram_addr,            32'd0);
    chk({tag, ".sram_wdata"},  sram_wdata,           32'd0);
  endtask

  initial begin
    logic prev_i;
    logic prev_d;
    logic exp_i;

    // Reset held with both ports requesting: everything stays zero.
    rst        = 1'b1;
    sram_rdata = 32'h0;
    drive(1'b1, 32'hBFC0_0000, 1'b1, 4'b0000, 32'h8000_1000, 32'h0);
    @(negedge clk);
    chk_all_zero("reset");
    next_cycle();

    // First cycle out of reset: lone fetch granted immediately.
    rst = 1'b0;
    drive(1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    chk("fetch.inst_gnt",   {31'd0, inst_gnt}, 32'd1);
    chk("fetch.data_gnt",   {31'd0, data_gnt}, 32'd0);
    chk("fetch.sram_en",    {31'd0, sram_en},  32'd1);
    chk("fetch.sram_addr",  sram_addr,         32'hBFC0_0000);
    chk("fetch.sram_wen",   {28'd0, sram_wen}, 32'd0);
    chk("fetch.sram_wdata", sram_wdata,        32'd0);
    next_cycle();

    // Fetch returns; meanwhile both request and data read wins.
    sram_rdata = 32'hDEAD_BEEF;
    drive(1'b1, 32'h0000_0100, 1'b1, 4'b0000, 32'h8000_1000, 32'h5555_5555);
    @(negedge clk);
    chk("fret.inst_rvalid", {31'd0, inst_rvalid}, 32'd1);
    chk("fret.inst_rdata",  inst_rdata,           32'hDEAD_BEEF);
    chk("fret.data_rvalid", {31'd0, data_rvalid}, 32'd0);
    chk("coll.data_gnt",    {31'd0, data_gnt},    32'd1);
    chk("coll.inst_gnt",    {31'd0, inst_gnt},    32'd0);
    chk("coll.sram_addr",   sram_addr,            32'h8000_1000);
    chk("coll.sram_wdata",  sram_wdata,           32'h5555_5555);
    next_cycle();

    // Both requests withdrawn: data read returns, SRAM idle, fetch dropped.
    sram_rdata = 32'h1122_3344;
    drive(1'b0, 32'h0000_0100, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    chk("dret.data_rvalid", {31'd0, data_rvalid}, 32'd1);
    chk("dret.data_rdata",  data_rdata,           32'h1122_3344);
    chk("dret.inst_rvalid", {31'd0, inst_rvalid}, 32'd0);
    chk("dret.sram_en",     {31'd0, sram_en},     32'd0);
    chk("dret.sram_addr",   sram_addr,            32'd0);
    next_cycle();

    // Store: halfword byte enables pass through, no return afterwards.
    drive(1'b0, 32'h0, 1'b1, 4'b0011, 32'h8000_0010, 32'h1234_ABCD);
    @(negedge clk);
    chk("store.data_gnt",   {31'd0, data_gnt}, 32'd1);
    chk("store.sram_en",    {31'd0, sram_en},  32'd1);
    chk("store.sram_wen",   {28'd0, sram_wen}, 32'h3);
    chk("store.sram_wdata", sram_wdata,        32'h1234_ABCD);
    chk("store.sram_addr",  sram_addr,         32'h8000_0010);
    next_cycle();

    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    chk("store_ret.data_rvalid", {31'd0, data_rvalid}, 32'd0);
    chk("store_ret.inst_rvalid", {31'd0, inst_rvalid}, 32'd0);
    next_cycle();

    // Both held continuously: four data grants, one fetch, repeating.
    prev_i = 1'b0;
    prev_d = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 32'h0000_0200, 1'b1, 4'b0000, 32'h8000_2000, 32'h0);
      @(negedge clk);
      exp_i = (k % 5 == 0);
      chk($sformatf("starve%0d.inst_gnt", k),    {31'd0, inst_gnt},    {31'd0, exp_i});
      chk($sformatf("starve%0d.data_gnt", k),    {31'd0, data_gnt},    {31'd0, !exp_i});
      chk($sformatf("starve%0d.inst_rvalid", k), {31'd0, inst_rvalid}, {31'd0, prev_i});
      chk($sformatf("starve%0d.data_rvalid", k), {31'd0, data_rvalid}, {31'd0, prev_d});
      prev_i = exp_i;
      prev_d = !exp_i;
      next_cycle();
    end

    // Three more data grants push the counter to 3, then a reset must clear it.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("pre_rst%0d.data_gnt", k), {31'd0, data_gnt}, 32'd1);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_after_dread");
    next_cycle();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d.data_gnt", k), {31'd0, data_gnt}, {31'd0, k != 5});
      chk($sformatf("post_rst%0d.inst_gnt", k), {31'd0, inst_gnt}, {31'd0, k == 5});
      next_cycle();
    end

    // Fetch grant followed by reset: its return is cancelled.
    drive(1'b1, 32'h0000_0300, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_fetch.inst_gnt", {31'd0, inst_gnt}, 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_after_iread");
    next_cycle();
    rst = 1'b0;

    // Alternating fetch / load every cycle: each return goes to its owner.
    prev_i = 1'b0;
    prev_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_i = (k % 2 == 0);
      sram_rdata = 32'hA000_0000 + k;
      drive(exp_i, 32'h0000_1000 + 4 * k, !exp_i, 4'b0000, 32'h8000_3000 + 4 * k, 32'h0);
      @(negedge clk);
      chk($sformatf("alt%0d.inst_gnt", k),    {31'd0, inst_gnt},    {31'd0, exp_i});
      chk($sformatf("alt%0d.data_gnt", k),    {31'd0, data_gnt},    {31'd0, !exp_i});
      chk($sformatf("alt%0d.sram_addr", k),   sram_addr,
          exp_i ? 32'h0000_1000 + 4 * k : 32'h8000_3000 + 4 * k);
      chk($sformatf("alt%0d.inst_rvalid", k), {31'd0, inst_rvalid}, {31'd0, prev_i});
      chk($sformatf("alt%0d.data_rvalid", k), {31'd0, data_rvalid}, {31'd0, prev_d});
      prev_i = exp_i;
      prev_d = !exp_i;
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    chk("alt_tail.data_rvalid", {31'd0, data_rvalid}, 32'd1);
    chk("alt_tail.inst_rvalid", {31'd0, inst_rvalid}, 32'd0);
    chk("alt_tail.sram_en",     {31'd0, sram_en},     32'd0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sram_port_arbiter

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while inst_req is pending.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 inst_req  in  1  instruction-fetch read request, held until granted.
REQ-006 inst_addr  in  AW  fetch address.
REQ-007 inst_gnt  out  1  fetch request accepted this cycle.
REQ-008 inst_rvalid  out  1  inst_rdata valid this cycle.
REQ-009 inst_rdata  out  32  fetch read data.
REQ-010 data_req  in  1  load/store request, held until granted.
REQ-011 data_wen  in  4  byte write enables; 4'b0000 means read.
REQ-012 data_addr  in  AW  load/store address.
REQ-013 data_wdata  in  32  store data.
REQ-014 data_gnt  out  1  data request accepted this cycle.
REQ-015 data_rvalid  out  1  data_rdata valid this cycle (reads only).
REQ-016 data_rdata  out  32  load read data.
REQ-017 sram_en  out  1  SRAM access enable.
REQ-018 sram_wen  out  4  SRAM byte write enables.
REQ-019 sram_addr  out  AW  SRAM address.
REQ-020 sram_wdata  out  32  SRAM write data.
REQ-021 sram_rdata  in  32  SRAM read data, valid one cycle after sram_en with sram_wen==0.

Function
REQ-022 The arbiter SHALL grant at most one requester per cycle, combinationally, in the cycle the request is seen; the grant and SRAM drive are both in that cycle.
REQ-023 Granted requester's addr/wen/wdata SHALL drive sram_*; inst grant drives sram_wen=0, sram_wdata=0.
REQ-024 No grant: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
REQ-025 Only one request: that requester SHALL be granted.
REQ-026 Both requesting: data SHALL win unless starve_cnt==STARVE_LIMIT, in which case inst SHALL win.
REQ-027 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment when data is granted while inst_req=1, clear when inst is granted or inst_req=0, and saturate at STARVE_LIMIT.
REQ-028 Owner state register SHALL take values IDLE, INST_RD, DATA_RD: next state INST_RD on inst grant, DATA_RD on data read grant, IDLE otherwise (including data write grant).
REQ-029 inst_rvalid SHALL be 1 exactly when state==INST_RD; data_rvalid exactly when state==DATA_RD; read latency is one cycle after grant.
REQ-030 inst_rdata and data_rdata SHALL both equal sram_rdata; consumers qualify with rvalid.
REQ-031 Back-to-back grants SHALL be allowed every cycle; a return of an earlier read and a new grant may coincide.
REQ-032 Data writes SHALL produce no rvalid.
REQ-033 Requests deasserted before grant SHALL be dropped without side effects.

Reset
REQ-034 While rst=1: state=IDLE, starve_cnt=0, all gnt/rvalid outputs=0, sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0, regardless of requests.
REQ-035 Reset asserted in the cycle after a read grant SHALL cancel that read's rvalid.
REQ-036 The first grant SHALL occur in the first cycle with rst=0.

Structure
REQ-037 Owner state encoding (IDLE/INST_RD/DATA_RD) and the read-enable constant 4'b0000 SHALL live in the shared CPU package.
REQ-038 No sub-module; a single module containing the grant logic, state register and starve counter.

Verification
REQ-039 inst_req only, addr=0xBFC00000 -> inst_gnt same cycle, sram_addr=0xBFC00000, sram_wen=0; next cycle inst_rvalid=1, inst_rdata=sram_rdata.
REQ-040 inst_req and data_req (read, addr=0x80001000) same cycle -> data_gnt=1, inst_gnt=0; next cycle data_rvalid=1, inst_rvalid=0.
REQ-041 Both held continuously, STARVE_LIMIT=4 -> data granted 4 cycles, inst granted cycle 5, data granted cycle 6; repeats.
REQ-042 data store wen=4'b0011, wdata=0x1234ABCD -> sram_wen=4'b0011, sram_wdata=0x1234ABCD, data_gnt=1, no rvalid next cycle.
REQ-043 inst grant at cycle N, rst=1 at N+1 -> inst_rvalid=0 at N+1, all outputs 0, starve_cnt=0.
REQ-044 Alternating inst/data reads every cycle -> one rvalid per grant, each to the correct owner, no bubbles.
